// File: rtl/dl_origin_scheduler_pkg.sv
// Shared types and width helpers for the deadlock-detector origin scheduler.
package dl_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_QUALIFY,
        S_PROBE,
        S_CLEAR,
        S_DETECTED
    } dl_sched_state_t;

    localparam int DL_MIN_IDX_W = 1;

    function automatic int CLOG2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) r = i + 1;
        end
        return r;
    endfunction

    // A single process still needs a one-bit index.
    function automatic int IDX_W_OF(input int n);
        return (CLOG2(n) < DL_MIN_IDX_W) ? DL_MIN_IDX_W : CLOG2(n);
    endfunction

endpackage

// File: rtl/dl_origin_scheduler_if.sv
// Bundle between the scheduler, the per-process detect units and the report unit.
interface dl_origin_scheduler_if
    import dl_sched_pkg::*;
#(
    parameter int N_PROC = 2
);
    localparam int IDX_W = IDX_W_OF(N_PROC);

    logic [N_PROC-1:0] blk_vec;
    logic [N_PROC-1:0] dl_in_vec;
    logic              all_finish;
    logic [N_PROC-1:0] origin;
    logic              token_clear;
    logic              dl_detect_out;
    logic [IDX_W-1:0]  dl_proc_idx;

    modport master (
        output blk_vec, dl_in_vec, all_finish,
        input  origin, token_clear, dl_detect_out, dl_proc_idx
    );

    modport slave (
        input  blk_vec, dl_in_vec, all_finish,
        output origin, token_clear, dl_detect_out, dl_proc_idx
    );

endinterface

// File: rtl/dl_origin_scheduler_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module dl_rr_pick #(
    parameter int N     = 2,
    parameter int IDX_W = 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             gnt_vld
);

    logic [IDX_W-1:0] w_idx;

    // Scan farthest-first so the candidate closest to ptr is assigned last and wins.
    always_comb begin
        gnt_idx = '0;
        gnt_vld = 1'b0;
        w_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_idx = IDX_W'((int'(ptr) + k) % N);
            if (req[w_idx]) begin
                gnt_idx = w_idx;
                gnt_vld = 1'b1;
            end
        end
    end

endmodule

// File: rtl/dl_origin_scheduler.sv
// Picks one blocked process at a time as token origin, waits for token return or
// timeout, and clears the detect ring between probes.
module dl_origin_scheduler
    import dl_sched_pkg::*;
#(
    parameter int N_PROC     = 2,
    parameter int STABLE_CYC = 4,
    parameter int TIMEOUT    = 16
) (
    input  logic                  dl_clock,
    input  logic                  dl_reset,
    dl_origin_scheduler_if.slave  bus
);

    localparam int IDX_W = IDX_W_OF(N_PROC);
    localparam int CW    = CLOG2((STABLE_CYC > TIMEOUT) ? STABLE_CYC : TIMEOUT);

    dl_sched_state_t   r_state;
    logic [IDX_W-1:0]  r_ptr;
    logic [IDX_W-1:0]  r_cand;
    logic [CW-1:0]     r_cnt;
    logic [N_PROC-1:0] r_origin;
    logic              r_token_clear;
    logic              r_detect;
    logic [IDX_W-1:0]  r_proc_idx;

    logic [IDX_W-1:0]  w_gnt_idx;
    logic              w_gnt_vld;
    logic [IDX_W-1:0]  w_ptr_next;

    dl_rr_pick #(
        .N     (N_PROC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (bus.blk_vec),
        .ptr     (r_ptr),
        .gnt_idx (w_gnt_idx),
        .gnt_vld (w_gnt_vld)
    );

    assign w_ptr_next = (r_cand == IDX_W'(N_PROC - 1)) ? '0 : r_cand + 1'b1;

    function automatic logic [N_PROC-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [N_PROC-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    always_ff @(posedge dl_clock or negedge dl_reset) begin
        if (!dl_reset) begin
            r_state       <= S_IDLE;
            r_ptr         <= '0;
            r_cand        <= '0;
            r_cnt         <= '0;
            r_origin      <= '0;
            r_token_clear <= 1'b0;
            r_detect      <= 1'b0;
            r_proc_idx    <= '0;
        end else begin
            r_token_clear <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_origin <= '0;
                    if (w_gnt_vld && !bus.all_finish) begin
                        r_cand  <= w_gnt_idx;
                        r_cnt   <= '0;
                        r_state <= S_QUALIFY;
                    end
                end
                S_QUALIFY: begin
                    if (!bus.blk_vec[r_cand] || bus.all_finish) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == CW'(STABLE_CYC - 1)) begin
                        r_state    <= S_PROBE;
                        r_origin   <= onehot(r_cand);
                        r_proc_idx <= r_cand;
                        r_cnt      <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                // Exit checks are ordered: finish beats token return beats unblock beats timeout.
                S_PROBE: begin
                    if (bus.all_finish || (!bus.dl_in_vec[r_cand] &&
                        (!bus.blk_vec[r_cand] || r_cnt == CW'(TIMEOUT - 1)))) begin
                        r_state       <= S_CLEAR;
                        r_origin      <= '0;
                        r_token_clear <= 1'b1;
                    end else if (bus.dl_in_vec[r_cand]) begin
                        r_state  <= S_DETECTED;
                        r_detect <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_CLEAR: begin
                    r_ptr   <= w_ptr_next;
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
                S_DETECTED: begin
                    r_state <= S_DETECTED;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.origin        = r_origin;
    assign bus.token_clear   = r_token_clear;
    assign bus.dl_detect_out = r_detect;
    assign bus.dl_proc_idx   = r_proc_idx;

endmodule

// File: tb/tb_dl_origin_scheduler.sv
// Directed bench for dl_origin_scheduler with N_PROC=2, STABLE_CYC=4, TIMEOUT=16.
module tb_dl_origin_scheduler;

    logic dl_clock;
    logic dl_reset;
    int   n_checks;
    int   n_pass;

    dl_origin_scheduler_if #(.N_PROC(2)) bus ();

    dl_origin_scheduler #(
        .N_PROC     (2),
        .STABLE_CYC (4),
        .TIMEOUT    (16)
    ) dut (
        .dl_clock (dl_clock),
        .dl_reset (dl_reset),
        .bus      (bus.slave)
    );

    initial dl_clock = 1'b0;
    always #5 dl_clock = ~dl_clock;

    task automatic step(input int n);
        repeat (n) @(posedge dl_clock);
        #1;
    endtask

    task automatic do_reset();
        bus.blk_vec    = '0;
        bus.dl_in_vec  = '0;
        bus.all_finish = 1'b0;
        dl_reset       = 1'b0;
        step(2);
        dl_reset = 1'b1;
    endtask

    task automatic test_reset();
        bus.blk_vec    = '0;
        bus.dl_in_vec  = '0;
        bus.all_finish = 1'b0;
        dl_reset       = 1'b0;
        #3;
        n_checks++;
        if ({bus.origin, bus.token_clear, bus.dl_detect_out, bus.dl_proc_idx} !== 5'b0)
            $display("FAIL reset_held outputs=%b exp=%b",
                     {bus.origin, bus.token_clear, bus.dl_detect_out, bus.dl_proc_idx}, 5'b0);
        else n_pass++;
        step(2);
        dl_reset = 1'b1;
        for (int i = 0; i < 50; i++) begin
            step(1);
            n_checks++;
            if ({bus.origin, bus.token_clear, bus.dl_detect_out, bus.dl_proc_idx} !== 5'b0)
                $display("FAIL reset_idle cyc=%0d outputs=%b exp=%b", i,
                         {bus.origin, bus.token_clear, bus.dl_detect_out, bus.dl_proc_idx}, 5'b0);
            else n_pass++;
        end
    endtask

    task automatic test_deadlock();
        do_reset();
        bus.blk_vec = 2'b01;
        step(4);
        n_checks++;
        if (bus.origin !== 2'b00) $display("FAIL dl_qualify origin=%b exp=%b", bus.origin, 2'b00);
        else n_pass++;
        step(1);
        n_checks++;
        if (bus.origin !== 2'b01) $display("FAIL dl_origin origin=%b exp=%b", bus.origin, 2'b01);
        else n_pass++;
        n_checks++;
        if (bus.dl_proc_idx !== 1'b0) $display("FAIL dl_idx idx=%b exp=%b", bus.dl_proc_idx, 1'b0);
        else n_pass++;
        step(5);
        bus.dl_in_vec = 2'b01;
        n_checks++;
        if (bus.dl_detect_out !== 1'b0) $display("FAIL dl_not_yet detect=%b exp=%b", bus.dl_detect_out, 1'b0);
        else n_pass++;
        step(1);
        bus.dl_in_vec  = 2'b00;
        bus.all_finish = 1'b1;
        n_checks++;
        if (bus.dl_detect_out !== 1'b1) $display("FAIL dl_detect detect=%b exp=%b", bus.dl_detect_out, 1'b1);
        else n_pass++;
        step(100);
        n_checks++;
        if ({bus.dl_detect_out, bus.origin, bus.dl_proc_idx, bus.token_clear} !== 5'b1_01_0_0)
            $display("FAIL dl_sticky got=%b exp=%b",
                     {bus.dl_detect_out, bus.origin, bus.dl_proc_idx, bus.token_clear}, 5'b1_01_0_0);
        else n_pass++;
    endtask

    task automatic test_timeout_rotation();
        do_reset();
        bus.blk_vec = 2'b11;
        step(5);
        n_checks++;
        if (bus.origin !== 2'b01) $display("FAIL rot_first origin=%b exp=%b", bus.origin, 2'b01);
        else n_pass++;
        bus.dl_in_vec = 2'b10;
        for (int i = 1; i < 16; i++) begin
            step(1);
            n_checks++;
            if ({bus.origin, bus.token_clear} !== 3'b01_0)
                $display("FAIL rot_probe cyc=%0d origin,clr=%b exp=%b", i, {bus.origin, bus.token_clear}, 3'b01_0);
            else n_pass++;
        end
        step(1);
        bus.dl_in_vec = 2'b00;
        n_checks++;
        if ({bus.origin, bus.token_clear, bus.dl_detect_out} !== 4'b00_1_0)
            $display("FAIL rot_clear origin,clr,det=%b exp=%b",
                     {bus.origin, bus.token_clear, bus.dl_detect_out}, 4'b00_1_0);
        else n_pass++;
        for (int i = 0; i < 5; i++) begin
            step(1);
            n_checks++;
            if ({bus.origin, bus.token_clear} !== 3'b00_0)
                $display("FAIL rot_gap cyc=%0d origin,clr=%b exp=%b", i, {bus.origin, bus.token_clear}, 3'b00_0);
            else n_pass++;
        end
        step(1);
        n_checks++;
        if ({bus.origin, bus.dl_proc_idx} !== 3'b10_1)
            $display("FAIL rot_second origin,idx=%b exp=%b", {bus.origin, bus.dl_proc_idx}, 3'b10_1);
        else n_pass++;
    endtask

    task automatic test_glitch();
        do_reset();
        bus.blk_vec = 2'b10;
        step(3);
        bus.blk_vec = 2'b00;
        for (int i = 0; i < 10; i++) begin
            step(1);
            n_checks++;
            if (bus.origin !== 2'b00) $display("FAIL glitch_origin cyc=%0d origin=%b exp=%b", i, bus.origin, 2'b00);
            else n_pass++;
        end
        bus.blk_vec = 2'b11;
        step(5);
        n_checks++;
        if (bus.origin !== 2'b01) $display("FAIL glitch1_ptr origin=%b exp=%b", bus.origin, 2'b01);
        else n_pass++;
        do_reset();
        bus.blk_vec = 2'b01;
        step(3);
        bus.blk_vec = 2'b00;
        step(3);
        bus.blk_vec = 2'b11;
        step(5);
        n_checks++;
        if (bus.origin !== 2'b01) $display("FAIL glitch0_ptr origin=%b exp=%b", bus.origin, 2'b01);
        else n_pass++;
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.blk_vec = 2'b01;
        step(5);
        n_checks++;
        if (bus.origin !== 2'b01) $display("FAIL sim_origin origin=%b exp=%b", bus.origin, 2'b01);
        else n_pass++;
        step(2);
        bus.all_finish = 1'b1;
        bus.dl_in_vec  = 2'b01;
        step(1);
        bus.all_finish = 1'b0;
        bus.dl_in_vec  = 2'b00;
        bus.blk_vec    = 2'b00;
        n_checks++;
        if ({bus.token_clear, bus.dl_detect_out, bus.origin} !== 4'b1_0_00)
            $display("FAIL sim_clear clr,det,origin=%b exp=%b",
                     {bus.token_clear, bus.dl_detect_out, bus.origin}, 4'b1_0_00);
        else n_pass++;
        step(3);
        n_checks++;
        if ({bus.token_clear, bus.dl_detect_out} !== 2'b00)
            $display("FAIL sim_after clr,det=%b exp=%b", {bus.token_clear, bus.dl_detect_out}, 2'b00);
        else n_pass++;
    endtask

    // Relies on the pointer having advanced to process 1 in the previous scenario.
    task automatic test_mid_reset();
        bus.blk_vec = 2'b11;
        step(5);
        n_checks++;
        if (bus.origin !== 2'b10) $display("FAIL mrst_probe origin=%b exp=%b", bus.origin, 2'b10);
        else n_pass++;
        step(3);
        #2;
        dl_reset = 1'b0;
        #1;
        n_checks++;
        if ({bus.origin, bus.token_clear} !== 3'b00_0)
            $display("FAIL mrst_async origin,clr=%b exp=%b", {bus.origin, bus.token_clear}, 3'b00_0);
        else n_pass++;
        @(posedge dl_clock);
        #1;
        dl_reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1);
            n_checks++;
            if ({bus.origin, bus.token_clear} !== 3'b00_0)
                $display("FAIL mrst_gap cyc=%0d origin,clr=%b exp=%b", i, {bus.origin, bus.token_clear}, 3'b00_0);
            else n_pass++;
        end
        step(1);
        n_checks++;
        if ({bus.origin, bus.dl_proc_idx} !== 3'b01_0)
            $display("FAIL mrst_next origin,idx=%b exp=%b", {bus.origin, bus.dl_proc_idx}, 3'b01_0);
        else n_pass++;
    endtask

    initial begin
        n_checks = 0;
        n_pass   = 0;
        test_reset();
        test_deadlock();
        test_timeout_rotation();
        test_glitch();
        test_simultaneous();
        test_mid_reset();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dl_origin_scheduler.md
# dl_origin_scheduler

Sequencer for the simulation-only dataflow deadlock detector. It watches per-process blocked indications and picks one blocked process at a time, round-robin, as token origin for the detect-unit ring. It then waits for the token to return (deadlock confirmed) or for a timeout, and clears the ring between probes. It sits between the per-process detect units and the report unit, and drives their `origin`, `token_clear` and `dl_detect_in` inputs.

## Interface
- `N_PROC`, default 2: number of dataflow processes in the ring.
- `STABLE_CYC`, default 4: consecutive cycles a candidate must stay blocked before probing (≥1).
- `TIMEOUT`, default 16: PROBE cycles allowed for the token to return (≥2).
- `dl_clock` in 1: clock.
- `dl_reset` in 1: asynchronous, active-low reset.
- `blk_vec` in N_PROC: per-process blocked flag (OR of FIFO/PIPO/start/TLF/sync blocks).
- `dl_in_vec` in N_PROC: per-unit "token returned to origin" flag.
- `all_finish` in 1: simulation completed normally.
- `origin` out N_PROC: one-hot origin select, all-zero when not probing.
- `token_clear` out 1: one-cycle ring clear pulse.
- `dl_detect_out` out 1: sticky deadlock-confirmed flag.
- `dl_proc_idx` out clog2(N_PROC) (min 1): index of the current/confirmed origin.

## Operation
- States: IDLE, QUALIFY, PROBE, CLEAR, DETECTED. All outputs are registered.
- IDLE: `origin`=0. If `blk_vec`≠0 and `all_finish`=0, the picker selects the first set bit at or after `ptr` (wrapping) as `cand` and the FSM goes to QUALIFY with `cnt`=0.
- QUALIFY:
  - `blk_vec[cand]`=0 or `all_finish`=1 → IDLE; `ptr` unchanged.
  - Otherwise `cnt`++. When `cnt`==STABLE_CYC-1 → PROBE, with `origin`=onehot(cand), `cnt`=0 and `dl_proc_idx`=cand.
- PROBE: `origin` held; `cnt`++ each cycle. Priority, highest first:
  1. `all_finish` → CLEAR.
  2. `dl_in_vec[cand]` → DETECTED.
  3. `blk_vec[cand]`=0 → CLEAR.
  4. `cnt`==TIMEOUT-1 → CLEAR.
- CLEAR: `token_clear`=1 for exactly one cycle and `origin`=0. `ptr`=(cand+1) mod N_PROC. → IDLE.
- DETECTED: `dl_detect_out`=1, `origin` and `dl_proc_idx` held. Terminal until reset; `all_finish` is ignored here.
- `dl_in_vec` bits other than `cand` are ignored in every state.
- `cnt` width is clog2(max(STABLE_CYC,TIMEOUT)). `cnt` never wraps, because every terminal count forces a state exit.

## Timing
- Reset: state IDLE, `ptr`=0, `cnt`=0, `origin`=0, `token_clear`=0, `dl_detect_out`=0, `dl_proc_idx`=0.
- Assertion of `dl_reset` mid-probe clears `origin` asynchronously. No `token_clear` pulse is emitted on reset.
- If `blk_vec[i]` is sampled high in IDLE at cycle t and stays high, `origin[i]` is high from cycle t+STABLE_CYC+1.
- If `dl_in_vec[cand]` is sampled high at PROBE cycle p, `dl_detect_out` is high from p+1.
- With no token return, the last PROBE cycle is the TIMEOUT-th. `token_clear` is high in the following cycle, and IDLE is re-entered one cycle later.
- Minimum gap between two probes: `origin` is low for ≥2 cycles (CLEAR plus IDLE).
- `dl_detect_out` depends on `dl_in_vec` only through the registered state; there is no combinational path from `dl_in_vec` to `dl_detect_out`.

## Structure
- Package `dl_sched_pkg` holds:
  - state enum `dl_sched_state_t`
  - `CLOG2` function
  - index-width localparam helper
- Sub-module `dl_rr_pick` (combinational):
  - inputs: `req`[N], `ptr`
  - outputs: `gnt_idx`, `gnt_vld`
  - selection: first set bit at or after `ptr`, wrapping
- Top level is the FSM plus counters only. It is instantiated once per dataflow region.

## Test plan
All scenarios use N_PROC=2, STABLE_CYC=4, TIMEOUT=16.
- Reset: release `dl_reset` with all inputs 0 → all outputs 0 for 50 cycles.
- Confirmed deadlock:
  - Stimulus: `blk_vec`=2'b01 from cycle 10; `dl_in_vec`=2'b01 at cycle 20.
  - Response: `origin`=2'b01 from cycle 15, `dl_detect_out`=1 from cycle 21, `dl_proc_idx`=0; state unchanged 100 cycles later.
- Timeout and rotation:
  - Stimulus: `blk_vec`=2'b11 held, `dl_in_vec`=0.
  - Response: `origin`=01 for 16 cycles, then `token_clear` one pulse, then after ≥2 idle cycles `origin`=10.
- Glitch filter: `blk_vec[1]` high for 3 cycles, then low → `origin` never asserts and `ptr` is unchanged.
- Simultaneous events: in PROBE, assert `all_finish` and `dl_in_vec[cand]` in the same cycle → `token_clear` pulse, and `dl_detect_out` stays 0.
- Mid-probe reset: pulse `dl_reset` low during PROBE → `origin`=0 immediately, no `token_clear` pulse, and the next probe selects process 0.
